dotp_axil_regs: RTL and testbench
=================================

// Module: dotp_axil_regs
// PURPOSE
//  AXI4-Lite subordinate (responder) register file for the dot-product accelerator.
//  Terminates the S00_AXI control port driven by the host/testbench initiator.
//  Drives configuration and start to the dot-product core; captures its result and status.
// PARAMETERS
//  ADDR_W  5   AXI-Lite address width; decode uses addr[4:2], addr[1:0] ignored
//  DATA_W  32  AXI-Lite data width; only 32 supported
// PORTS
//  clk              in   1   system clock
//  rst              in   1   asynchronous reset, active-high
//  S00_AXI_awaddr   in   5   write address;  S00_AXI_awprot in 3 (ignored)
//  S00_AXI_awvalid/awready   in/out 1  AW handshake
//  S00_AXI_wdata    in   32  write data;  S00_AXI_wstrb in 4 byte enables
//  S00_AXI_wvalid/wready     in/out 1  W handshake
//  S00_AXI_bresp    out  2   00 OKAY, 10 SLVERR;  S00_AXI_bvalid/bready out/in 1
//  S00_AXI_araddr   in   5   read address;  S00_AXI_arprot in 3 (ignored)
//  S00_AXI_arvalid/arready   in/out 1  AR handshake
//  S00_AXI_rdata    out  32  read data;  S00_AXI_rresp out 2
//  S00_AXI_rvalid/rready     out/in 1  R handshake
//  core_start       out  1   one-cycle start pulse to core
//  vec_a_addr/vec_b_addr out 32  vector base addresses;  vec_len out 32  element count
//  core_busy        in   1   core computing;  core_done in 1 one-cycle completion pulse
//  core_error       in   1   one-cycle error pulse;  core_result in 32 dot-product result
// BEHAVIOUR
//  Map: 0x00 CTRL (W: bit0=start, reads 0); 0x04 VEC_A; 0x08 VEC_B; 0x0C LEN (RW);
//   0x10 RESULT (RO); 0x14 STATUS (RO bit0 done, bit1 error, bit2 busy, bit3 start_rej;
//   bits0,1,3 W1C). 0x18/0x1C unmapped.
//  Reset: all regs 0, all outputs 0; awready/wready/arready rise first clk after rst low.
//  Write: AW and W accepted independently, any order or same cycle; each latched once,
//   its ready low until the write commits. Commit on cycle both held: regs updated per
//   wstrb; bvalid next cycle. bvalid held until bready; awready/wready stay low until B done.
//  Write to RESULT: ignored, OKAY. Unmapped write: ignored, SLVERR.
//  Read: arready high when no R pending; AR handshake -> rvalid+rdata next cycle,
//   held stable until rready. Unmapped read: rdata 0, SLVERR. Same-cycle read and
//   write commit to same reg: read returns old value.
//  Start: CTRL write with wstrb[0] & wdata[0]:
//   - core_busy=0, LEN!=0: core_start high exactly 1 cycle after commit; clears done/error.
//   - core_busy=0, LEN==0: no core_start; done set, RESULT=0 next cycle.
//   - core_busy=1: ignored, start_rej set.
//  core_done pulse: RESULT<=core_result, done<=1. core_error: error<=1.
//  Set beats W1C clear on same cycle. STATUS.busy mirrors core_busy (no latency).
//  vec_a_addr/vec_b_addr/vec_len are direct register outputs; writes take effect 1 cycle
//   after commit, even while busy (core samples them at start).
//  rst mid-transaction: valid/ready/start drop at once; pending AW/W/B/R discarded.
// TESTING
//  1 Write 0x04=C0000000, 0x08=D0000000, 0x0C=256; read back -> same values, OKAY.
//  2 W before AW by 3 cycles, then AW at 0x0C -> single commit, 1 bvalid, LEN updated.
//  3 Write CTRL=1 -> core_start 1 cycle; core_done with result 1398144 ->
//    read 0x10 = 1398144, 0x14 bit0=1; W1C 0x14=1 -> bit0=0.
//  4 CTRL=1 while core_busy=1 -> no core_start, 0x14 bit3=1; LEN=0 start -> done, RESULT 0.
//  5 Read 0x18 -> rdata 0 SLVERR; write 0x1C -> SLVERR, no reg change; bready low 5
//    cycles -> bvalid/bresp held, awready low.
//  6 Assert rst with rvalid pending -> rvalid 0 immediately, all regs 0 after release.

Source files
------------

// File: rtl/dotp_axil_regs.sv
// AXI4-Lite register file for the dot-product accelerator.
// Holds vector base addresses and length, launches the core, and captures
// its result and sticky status flags for the host.
module dotp_axil_regs #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     S00_AXI_awaddr,
   input  logic [2:0]            S00_AXI_awprot,
   input  logic                  S00_AXI_awvalid,
   output logic                  S00_AXI_awready,
   input  logic [DATA_W-1:0]     S00_AXI_wdata,
   input  logic [DATA_W/8-1:0]   S00_AXI_wstrb,
   input  logic                  S00_AXI_wvalid,
   output logic                  S00_AXI_wready,
   output logic [1:0]            S00_AXI_bresp,
   output logic                  S00_AXI_bvalid,
   input  logic                  S00_AXI_bready,
   input  logic [ADDR_W-1:0]     S00_AXI_araddr,
   input  logic [2:0]            S00_AXI_arprot,
   input  logic                  S00_AXI_arvalid,
   output logic                  S00_AXI_arready,
   output logic [DATA_W-1:0]     S00_AXI_rdata,
   output logic [1:0]            S00_AXI_rresp,
   output logic                  S00_AXI_rvalid,
   input  logic                  S00_AXI_rready,
   output logic                  core_start,
   output logic [DATA_W-1:0]     vec_a_addr,
   output logic [DATA_W-1:0]     vec_b_addr,
   output logic [DATA_W-1:0]     vec_len,
   input  logic                  core_busy,
   input  logic                  core_done,
   input  logic                  core_error,
   input  logic [DATA_W-1:0]     core_result
);

   localparam logic [2:0] IDX_CTRL   = 3'd0;
   localparam logic [2:0] IDX_VEC_A  = 3'd1;
   localparam logic [2:0] IDX_VEC_B  = 3'd2;
   localparam logic [2:0] IDX_LEN    = 3'd3;
   localparam logic [2:0] IDX_RESULT = 3'd4;
   localparam logic [2:0] IDX_STATUS = 3'd5;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_SLV   = 2'b10;

   logic                rdy_en_q, rdy_en_d;
   logic                aw_held_q, aw_held_d;
   logic [2:0]          aw_idx_q, aw_idx_d;
   logic                w_held_q, w_held_d;
   logic [DATA_W-1:0]   w_data_q, w_data_d;
   logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic                rvalid_q, rvalid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [DATA_W-1:0]   vec_a_q, vec_a_d;
   logic [DATA_W-1:0]   vec_b_q, vec_b_d;
   logic [DATA_W-1:0]   len_q, len_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                rej_q, rej_d;
   logic                start_q, start_d;

   logic       aw_hs, w_hs, ar_hs, commit, start_req;
   logic [2:0] ar_idx;

   // Protection bits and byte-lane address bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{S00_AXI_awprot, S00_AXI_arprot,
                          S00_AXI_awaddr[1:0], S00_AXI_araddr[1:0]};

   // Readies stay low until the first clock after reset has been released.
   assign S00_AXI_awready = rdy_en_q & ~aw_held_q & ~bvalid_q;
   assign S00_AXI_wready  = rdy_en_q & ~w_held_q & ~bvalid_q;
   assign S00_AXI_arready = rdy_en_q & ~rvalid_q;
   assign S00_AXI_bvalid  = bvalid_q;
   assign S00_AXI_bresp   = bresp_q;
   assign S00_AXI_rvalid  = rvalid_q;
   assign S00_AXI_rdata   = rdata_q;
   assign S00_AXI_rresp   = rresp_q;
   assign core_start      = start_q;
   assign vec_a_addr      = vec_a_q;
   assign vec_b_addr      = vec_b_q;
   assign vec_len         = len_q;

   assign aw_hs     = S00_AXI_awvalid & S00_AXI_awready;
   assign w_hs      = S00_AXI_wvalid & S00_AXI_wready;
   assign ar_hs     = S00_AXI_arvalid & S00_AXI_arready;
   assign commit    = aw_held_q & w_held_q;
   assign ar_idx    = S00_AXI_araddr[4:2];
   assign start_req = commit & (aw_idx_q == IDX_CTRL) & w_strb_q[0] & w_data_q[0];

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0]   old_v,
                                                input logic [DATA_W-1:0]   new_v,
                                                input logic [DATA_W/8-1:0] strb);
      merge = old_v;
      for (int i = 0; i < DATA_W/8; i++)
         if (strb[i]) merge[i*8 +: 8] = new_v[i*8 +: 8];
   endfunction

   // AXI channel bookkeeping: latch AW/W independently, commit when both held.
   always_comb begin
      rdy_en_d  = 1'b1;
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = S00_AXI_awaddr[4:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = S00_AXI_wdata;
         w_strb_d = S00_AXI_wstrb;
      end
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = (aw_idx_q > IDX_STATUS) ? RESP_SLV : RESP_OKAY;
      end else if (bvalid_q && S00_AXI_bready) begin
         bvalid_d = 1'b0;
      end
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = RESP_OKAY;
         case (ar_idx)
            IDX_CTRL:   rdata_d = '0;
            IDX_VEC_A:  rdata_d = vec_a_q;
            IDX_VEC_B:  rdata_d = vec_b_q;
            IDX_LEN:    rdata_d = len_q;
            IDX_RESULT: rdata_d = result_q;
            IDX_STATUS: rdata_d = {{(DATA_W-4){1'b0}}, rej_q, core_busy, error_q, done_q};
            default: begin
               rdata_d = '0;
               rresp_d = RESP_SLV;
            end
         endcase
      end else if (rvalid_q && S00_AXI_rready) begin
         rvalid_d = 1'b0;
      end
   end

   // Register updates; core events are applied last so a set wins over W1C.
   always_comb begin
      vec_a_d  = vec_a_q;
      vec_b_d  = vec_b_q;
      len_d    = len_q;
      result_d = result_q;
      done_d   = done_q;
      error_d  = error_q;
      rej_d    = rej_q;
      start_d  = 1'b0;
      if (commit) begin
         case (aw_idx_q)
            IDX_VEC_A: vec_a_d = merge(vec_a_q, w_data_q, w_strb_q);
            IDX_VEC_B: vec_b_d = merge(vec_b_q, w_data_q, w_strb_q);
            IDX_LEN:   len_d   = merge(len_q, w_data_q, w_strb_q);
            IDX_STATUS: begin
               if (w_strb_q[0]) begin
                  if (w_data_q[0]) done_d  = 1'b0;
                  if (w_data_q[1]) error_d = 1'b0;
                  if (w_data_q[3]) rej_d   = 1'b0;
               end
            end
            default: ;
         endcase
      end
      if (start_req) begin
         if (core_busy) begin
            rej_d = 1'b1;
         end else if (len_q != '0) begin
            start_d = 1'b1;
            done_d  = 1'b0;
            error_d = 1'b0;
         end else begin
            done_d   = 1'b1;
            result_d = '0;
         end
      end
      if (core_done) begin
         result_d = core_result;
         done_d   = 1'b1;
      end
      if (core_error) error_d = 1'b1;
   end

   // State register; reset drops every valid/ready and discards pending beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en_q  <= 1'b0;
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         vec_a_q   <= '0;
         vec_b_q   <= '0;
         len_q     <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         rej_q     <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         rdy_en_q  <= rdy_en_d;
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         vec_a_q   <= vec_a_d;
         vec_b_q   <= vec_b_d;
         len_q     <= len_d;
         result_q  <= result_d;
         done_q    <= done_d;
         error_q   <= error_d;
         rej_q     <= rej_d;
         start_q   <= start_d;
      end
   end

endmodule

// File: tb/tb_dotp_axil_regs.sv
// Scoreboard bench for dotp_axil_regs: stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_dotp_axil_regs;

   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLV  = 2'b10;

   typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;
   typedef struct { string name; logic [31:0] data; logic [1:0] resp; } rexp_t;
   typedef struct { string name; logic [1:0] resp; } bexp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [4:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic        core_start;
   logic [31:0] vec_a_addr, vec_b_addr, vec_len;
   logic        core_busy = 1'b0;
   logic        core_done = 1'b0;
   logic        core_error = 1'b0;
   logic [31:0] core_result = '0;

   chk_t  chk_q[$];
   rexp_t exp_rq[$];
   bexp_t exp_bq[$];
   chk_t  mc;
   rexp_t mr;
   bexp_t mb;
   int    n_checks = 0;
   int    n_fail = 0;
   int    start_cnt = 0;
   int    b_cnt = 0;
   logic  last_start = 1'b0;

   dotp_axil_regs #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .S00_AXI_awaddr(awaddr), .S00_AXI_awprot(awprot),
      .S00_AXI_awvalid(awvalid), .S00_AXI_awready(awready),
      .S00_AXI_wdata(wdata), .S00_AXI_wstrb(wstrb),
      .S00_AXI_wvalid(wvalid), .S00_AXI_wready(wready),
      .S00_AXI_bresp(bresp), .S00_AXI_bvalid(bvalid), .S00_AXI_bready(bready),
      .S00_AXI_araddr(araddr), .S00_AXI_arprot(arprot),
      .S00_AXI_arvalid(arvalid), .S00_AXI_arready(arready),
      .S00_AXI_rdata(rdata), .S00_AXI_rresp(rresp),
      .S00_AXI_rvalid(rvalid), .S00_AXI_rready(rready),
      .core_start(core_start), .vec_a_addr(vec_a_addr), .vec_b_addr(vec_b_addr),
      .vec_len(vec_len), .core_busy(core_busy), .core_done(core_done),
      .core_error(core_error), .core_result(core_result)
   );

   always #5 clk = ~clk;

   // Monitor: drains queued direct checks and scores every R and B handshake.
   always @(negedge clk) begin
      while (chk_q.size() > 0) begin
         mc = chk_q.pop_front();
         n_checks++;
         if (mc.act !== mc.exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", mc.name, mc.act, mc.exp);
         end
      end
      if (rvalid && rready) begin
         n_checks++;
         if (exp_rq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_r: got data 0x%08h resp %0d, none expected", rdata, rresp);
         end else begin
            mr = exp_rq.pop_front();
            if (rdata !== mr.data || rresp !== mr.resp) begin
               n_fail++;
               $display("FAIL %s: got data 0x%08h resp %0d expected data 0x%08h resp %0d",
                        mr.name, rdata, rresp, mr.data, mr.resp);
            end
         end
      end
      if (bvalid && bready) begin
         n_checks++;
         if (exp_bq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_b: got resp %0d, none expected", bresp);
         end else begin
            mb = exp_bq.pop_front();
            if (bresp !== mb.resp) begin
               n_fail++;
               $display("FAIL %s: got resp %0d expected resp %0d", mb.name, bresp, mb.resp);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (core_start) start_cnt++;
      if (bvalid && bready) b_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_q.push_back('{nm, act, exp});
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input string nm, input bit wait_b);
      logic aw_hs, w_hs;
      bit   aw_done, w_done;
      int   n;
      exp_bq.push_back('{nm, er});
      @(negedge clk);
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      while (!(aw_done && w_done) && n < 50) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge clk);
         n++;
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
      end
      if (!(aw_done && w_done)) begin
         chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
         awvalid = 1'b0; wvalid = 1'b0;
      end
      n = 0;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      if (!bvalid) chk({nm, "_bvalid_timeout"}, 32'd0, 32'd1);
      last_start = core_start;
      if (wait_b) @(negedge clk);
   endtask

   task automatic axi_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er,
                           input string nm);
      int n;
      exp_rq.push_back('{nm, ed, er});
      @(negedge clk);
      araddr = a; arvalid = 1'b1; n = 0;
      while (!arready && n < 50) begin @(negedge clk); n++; end
      if (!arready) chk({nm, "_arready_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (!rvalid) chk({nm, "_rvalid_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic core_pulse(input logic d, input logic e, input logic [31:0] res);
      @(negedge clk);
      core_busy = 1'b0; core_done = d; core_error = e; core_result = res;
      @(negedge clk);
      core_done = 1'b0; core_error = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, b0, n;
      repeat (3) @(negedge clk);
      chk("awready_in_reset", {31'd0, awready}, 32'd0);
      rst = 1'b0;
      #1 chk("arready_at_release", {31'd0, arready}, 32'd0);
      @(negedge clk);
      chk("awready_after_reset", {31'd0, awready}, 32'd1);
      chk("wready_after_reset", {31'd0, wready}, 32'd1);
      chk("arready_after_reset", {31'd0, arready}, 32'd1);
      chk("valids_after_reset", {30'd0, bvalid, rvalid}, 32'd0);
      chk("vec_len_reset", vec_len, 32'd0);

      // Basic RW registers and byte strobes
      axi_write(5'h04, 32'hC000_0000, 4'hF, OKAY, "wr_vec_a", 1'b1);
      axi_write(5'h08, 32'hD000_0000, 4'hF, OKAY, "wr_vec_b", 1'b1);
      axi_write(5'h0C, 32'd256, 4'hF, OKAY, "wr_len", 1'b1);
      axi_read(5'h04, 32'hC000_0000, OKAY, "rd_vec_a");
      axi_read(5'h08, 32'hD000_0000, OKAY, "rd_vec_b");
      axi_read(5'h0C, 32'd256, OKAY, "rd_len");
      chk("vec_b_addr_out", vec_b_addr, 32'hD000_0000);
      axi_write(5'h04, 32'h1234_5678, 4'b0011, OKAY, "wr_vec_a_strb", 1'b1);
      axi_read(5'h04, 32'hC000_5678, OKAY, "rd_vec_a_strb");
      chk("vec_a_addr_out", vec_a_addr, 32'hC000_5678);

      // W three cycles ahead of AW: exactly one commit
      b0 = b_cnt;
      exp_bq.push_back('{"wr_len_w_first", OKAY});
      @(negedge clk);
      wdata = 32'h40; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("wready_low_while_w_held", {31'd0, wready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("no_b_before_aw", {31'd0, bvalid}, 32'd0);
      awaddr = 5'h0C; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      @(negedge clk);
      chk("w_first_single_b", b_cnt - b0, 32'd1);
      chk("w_first_len_out", vec_len, 32'h40);

      // RESULT is read-only
      axi_write(5'h10, 32'hDEAD, 4'hF, OKAY, "wr_result_ro", 1'b1);
      axi_read(5'h10, 32'd0, OKAY, "rd_result_unchanged");

      // Start, completion, W1C
      s0 = start_cnt;
      axi_write(5'h00, 32'd1, 4'h1, OKAY, "wr_ctrl_start", 1'b1);
      chk("start_with_bvalid", {31'd0, last_start}, 32'd1);
      chk("start_one_pulse", start_cnt - s0, 32'd1);
      core_busy = 1'b1;
      axi_read(5'h14, 32'h4, OKAY, "rd_status_busy");
      core_pulse(1'b1, 1'b0, 32'd1398144);
      axi_read(5'h10, 32'd1398144, OKAY, "rd_result");
      axi_read(5'h14, 32'h1, OKAY, "rd_status_done");
      axi_read(5'h00, 32'd0, OKAY, "rd_ctrl_zero");
      axi_write(5'h14, 32'h1, 4'h1, OKAY, "w1c_done", 1'b1);
      axi_read(5'h14, 32'h0, OKAY, "rd_status_cleared");
      core_pulse(1'b0, 1'b1, 32'd0);
      axi_read(5'h14, 32'h2, OKAY, "rd_status_error");

      // Start while busy is rejected; zero-length start completes at once
      core_busy = 1'b1;
      s0 = start_cnt;
      axi_write(5'h00, 32'd1, 4'h1, OKAY, "wr_ctrl_busy", 1'b1);
      chk("no_start_when_busy", start_cnt - s0, 32'd0);
      axi_read(5'h14, 32'hE, OKAY, "rd_status_rej");
      core_busy = 1'b0;
      axi_write(5'h14, 32'hF, 4'h1, OKAY, "w1c_all", 1'b1);
      axi_read(5'h14, 32'h0, OKAY, "rd_status_all_clear");
      axi_write(5'h0C, 32'd0, 4'hF, OKAY, "wr_len_zero", 1'b1);
      s0 = start_cnt;
      axi_write(5'h00, 32'd1, 4'h1, OKAY, "wr_ctrl_len0", 1'b1);
      chk("no_start_len0", start_cnt - s0, 32'd0);
      axi_read(5'h10, 32'd0, OKAY, "rd_result_len0");
      axi_read(5'h14, 32'h1, OKAY, "rd_status_len0");

      // Unmapped accesses and B backpressure
      axi_read(5'h18, 32'd0, SLV, "rd_unmapped");
      bready = 1'b0;
      axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, SLV, "wr_unmapped", 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bvalid_held", {31'd0, bvalid}, 32'd1);
         chk("bresp_held", {30'd0, bresp}, {30'd0, SLV});
         chk("awready_low_b_pending", {31'd0, awready}, 32'd0);
      end
      bready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      axi_read(5'h04, 32'hC000_5678, OKAY, "rd_vec_a_after_unmapped");
      axi_read(5'h08, 32'hD000_0000, OKAY, "rd_vec_b_after_unmapped");
      axi_read(5'h0C, 32'd0, OKAY, "rd_len_after_unmapped");

      // Reset with a read response pending
      @(negedge clk);
      rready = 1'b0;
      araddr = 5'h08; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      chk("rvalid_pending", {31'd0, rvalid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rvalid_drops_in_reset", {31'd0, rvalid}, 32'd0);
      chk("arready_drops_in_reset", {31'd0, arready}, 32'd0);
      chk("awready_drops_in_reset", {31'd0, awready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rready = 1'b1;
      @(negedge clk);
      chk("arready_back", {31'd0, arready}, 32'd1);
      chk("vec_a_after_rst", vec_a_addr, 32'd0);
      chk("vec_b_after_rst", vec_b_addr, 32'd0);
      axi_read(5'h10, 32'd0, OKAY, "rd_result_after_rst");
      axi_read(5'h14, 32'd0, OKAY, "rd_status_after_rst");
      axi_read(5'h08, 32'd0, OKAY, "rd_vec_b_after_rst");

      @(negedge clk);
      chk("r_queue_drained", exp_rq.size(), 32'd0);
      chk("b_queue_drained", exp_bq.size(), 32'd0);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
